// File: rtl/rainbow_animator_pkg.sv
// Shared definitions for the colour-wheel pixel source: mode encodings,
// wheel segment encoding and the derived hue-width constants.
package rainbow_animator_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_SCROLL = 2'd1,
    MODE_SOLID  = 2'd2,
    MODE_BLACK  = 2'd3
  } mode_e;

  // Wheel segment: which channel pair is currently cross-fading.
  typedef enum logic [1:0] {
    SEG_RG = 2'd0,
    SEG_GB = 2'd1,
    SEG_BR = 2'd2
  } seg_e;

  function automatic int calc_hb(input int color_bits);
    return color_bits + 2;
  endfunction

  function automatic int calc_seg(input int color_bits);
    return 1 << color_bits;
  endfunction

  function automatic int calc_hue_range(input int color_bits);
    return 3 * calc_seg(color_bits);
  endfunction

endpackage

// File: rtl/rainbow_animator_hue_to_rgb.sv
// Combinational hue -> RGB on a 3-segment wheel; blank forces black.
import rainbow_animator_pkg::*;

module hue_to_rgb #(
  parameter int COLOR_BITS = 6
) (
  input  logic [calc_hb(COLOR_BITS)-1:0] hue,
  input  logic                           blank,
  output logic [COLOR_BITS-1:0]          red,
  output logic [COLOR_BITS-1:0]          green,
  output logic [COLOR_BITS-1:0]          blue
);

  localparam int HB = calc_hb(COLOR_BITS);
  localparam logic [COLOR_BITS-1:0] CMAX = {COLOR_BITS{1'b1}};

  seg_e                  seg_s;
  logic [COLOR_BITS-1:0] frac_s;
  logic [COLOR_BITS-1:0] inv_s;

  // Decode segment and fraction, then pick the rising/falling channel pair
  always_comb begin
    seg_s  = seg_e'(hue[HB-1:COLOR_BITS]);
    frac_s = hue[COLOR_BITS-1:0];
    inv_s  = CMAX - frac_s;
    red    = {COLOR_BITS{1'b0}};
    green  = {COLOR_BITS{1'b0}};
    blue   = {COLOR_BITS{1'b0}};
    if (blank) begin
      red   = {COLOR_BITS{1'b0}};
      green = {COLOR_BITS{1'b0}};
      blue  = {COLOR_BITS{1'b0}};
    end else begin
      case (seg_s)
        SEG_RG: begin
          red   = inv_s;
          green = frac_s;
        end
        SEG_GB: begin
          green = inv_s;
          blue  = frac_s;
        end
        SEG_BR: begin
          red   = frac_s;
          blue  = inv_s;
        end
        default: begin
          red   = {COLOR_BITS{1'b0}};
          green = {COLOR_BITS{1'b0}};
          blue  = {COLOR_BITS{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: rtl/rainbow_animator.sv
// Pipelined colour-wheel pixel source: per-frame hue offset accumulator,
// stage 1 hue selection, stage 2 registered hue->RGB (2-cycle latency).
import rainbow_animator_pkg::*;

module rainbow_animator #(
  parameter int COL_BITS   = 6,
  parameter int COLOR_BITS = 6,
  parameter int HUE_STEP   = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [1:0]                     mode,
  input  logic [calc_hb(COLOR_BITS)-1:0] speed,
  input  logic                           direction,
  input  logic                           frame_tick,
  input  logic                           phase_clear,
  input  logic                           req_valid,
  input  logic [COL_BITS-1:0]            column_address,
  output logic                           out_valid,
  output logic [COLOR_BITS-1:0]          red,
  output logic [COLOR_BITS-1:0]          green,
  output logic [COLOR_BITS-1:0]          blue
);

  localparam int HB        = calc_hb(COLOR_BITS);
  localparam int HUE_RANGE = calc_hue_range(COLOR_BITS);
  localparam logic [HB:0]   HUE_RANGE_W = (HB+1)'(HUE_RANGE);
  localparam logic [HB-1:0] HUE_MAX     = HB'(HUE_RANGE - 1);

  if ((2 ** COL_BITS) * HUE_STEP > HUE_RANGE) begin : g_bad_cfg
    $error("rainbow_animator: 2^COL_BITS*HUE_STEP exceeds the hue range");
  end

  logic [HB-1:0]         offset_r;
  logic [HB-1:0]         offset_next_s;
  logic [HB-1:0]         spd_s;
  logic [HB:0]           inc_sum_s;
  logic [HB:0]           dec_sum_s;
  logic                  advance_s;

  logic [HB:0]           col_hue_s;
  logic [HB:0]           scroll_sum_s;
  logic [HB-1:0]         scroll_hue_s;
  logic [HB-1:0]         hue_sel_s;

  logic                  s1_valid_r;
  logic [HB-1:0]         s1_hue_r;
  logic                  s1_black_r;

  logic [COLOR_BITS-1:0] red_s;
  logic [COLOR_BITS-1:0] green_s;
  logic [COLOR_BITS-1:0] blue_s;
  logic                  out_valid_r;
  logic [COLOR_BITS-1:0] red_r;
  logic [COLOR_BITS-1:0] green_r;
  logic [COLOR_BITS-1:0] blue_r;

  // Next hue offset: clear beats tick; wrap modulo the hue range either way
  always_comb begin
    spd_s         = (speed > HUE_MAX) ? HUE_MAX : speed;
    inc_sum_s     = {1'b0, offset_r} + {1'b0, spd_s};
    dec_sum_s     = {1'b0, offset_r} + HUE_RANGE_W - {1'b0, spd_s};
    advance_s     = frame_tick && ((mode == MODE_SCROLL) || (mode == MODE_SOLID));
    offset_next_s = offset_r;
    if (phase_clear) begin
      offset_next_s = {HB{1'b0}};
    end else if (advance_s) begin
      if (direction) begin
        if (offset_r >= spd_s) begin
          offset_next_s = offset_r - spd_s;
        end else begin
          offset_next_s = HB'(dec_sum_s);
        end
      end else begin
        if (inc_sum_s >= HUE_RANGE_W) begin
          offset_next_s = HB'(inc_sum_s - HUE_RANGE_W);
        end else begin
          offset_next_s = inc_sum_s[HB-1:0];
        end
      end
    end else begin
      offset_next_s = offset_r;
    end
  end

  // Offset accumulator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      offset_r <= {HB{1'b0}};
    end else begin
      offset_r <= offset_next_s;
    end
  end

  // Stage 1 hue select; always uses the offset as it stood before this edge
  always_comb begin
    col_hue_s    = (HB+1)'(column_address) * (HB+1)'(HUE_STEP);
    scroll_sum_s = col_hue_s + {1'b0, offset_r};
    if (scroll_sum_s >= HUE_RANGE_W) begin
      scroll_hue_s = HB'(scroll_sum_s - HUE_RANGE_W);
    end else begin
      scroll_hue_s = scroll_sum_s[HB-1:0];
    end
    hue_sel_s = {HB{1'b0}};
    case (mode)
      MODE_STATIC: hue_sel_s = col_hue_s[HB-1:0];
      MODE_SCROLL: hue_sel_s = scroll_hue_s;
      MODE_SOLID:  hue_sel_s = offset_r;
      default:     hue_sel_s = {HB{1'b0}};
    endcase
  end

  // Stage 1 registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_hue_r   <= {HB{1'b0}};
      s1_black_r <= 1'b0;
    end else begin
      s1_valid_r <= req_valid;
      if (req_valid) begin
        s1_hue_r   <= hue_sel_s;
        s1_black_r <= (mode == MODE_BLACK);
      end
    end
  end

  hue_to_rgb #(
    .COLOR_BITS(COLOR_BITS)
  ) u_hue_to_rgb (
    .hue   (s1_hue_r),
    .blank (s1_black_r),
    .red   (red_s),
    .green (green_s),
    .blue  (blue_s)
  );

  // Stage 2 registers; colour holds while no result is valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      red_r       <= {COLOR_BITS{1'b0}};
      green_r     <= {COLOR_BITS{1'b0}};
      blue_r      <= {COLOR_BITS{1'b0}};
    end else begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        red_r   <= red_s;
        green_r <= green_s;
        blue_r  <= blue_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign red       = red_r;
  assign green     = green_r;
  assign blue      = blue_r;

endmodule

// File: tb/tb_rainbow_animator.sv
// Directed, table-driven bench for rainbow_animator at default parameters.
module tb_rainbow_animator;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] speed = 8'd0;
  logic       direction = 1'b0;
  logic       frame_tick = 1'b0;
  logic       phase_clear = 1'b0;
  logic       req_valid = 1'b0;
  logic [5:0] column_address = 6'd0;
  logic       out_valid;
  logic [5:0] red, green, blue;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      nm;
    logic [1:0] m;
    logic [5:0] c;
    logic [17:0] rgb;
  } vec_t;

  vec_t vecs[9];

  rainbow_animator dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .speed(speed),
    .direction(direction), .frame_tick(frame_tick), .phase_clear(phase_clear),
    .req_valid(req_valid), .column_address(column_address),
    .out_valid(out_valid), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [18:0] exp);
    logic [18:0] act;
    act = {out_valid, red, green, blue};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got v=%0b rgb=(%0d,%0d,%0d) want v=%0b rgb=(%0d,%0d,%0d)",
               nm, act[18], act[17:12], act[11:6], act[5:0],
               exp[18], exp[17:12], exp[11:6], exp[5:0]);
    end
  endtask

  // Independent wheel reference: segment by integer division of the hue.
  function automatic logic [17:0] wheel(input int hue);
    int s, f;
    s = hue / 64;
    f = hue % 64;
    if (s == 0) return {6'(63 - f), 6'(f), 6'd0};
    else if (s == 1) return {6'd0, 6'(63 - f), 6'(f)};
    else return {6'(f), 6'd0, 6'(63 - f)};
  endfunction

  task automatic single(input string nm, input logic [1:0] m, input logic [5:0] c,
                        input logic [17:0] rgb);
    mode = m; column_address = c; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check(nm, {1'b1, rgb});
  endtask

  task automatic clear_offset();
    phase_clear = 1'b1;
    tick();
    phase_clear = 1'b0;
  endtask

  task automatic frame(input logic [1:0] m, input logic [7:0] spd, input logic dir);
    mode = m; speed = spd; direction = dir; frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  initial begin
    int nvalid;
    vecs[0] = '{"static_c0",  2'd0, 6'd0,  {6'd63, 6'd0,  6'd0}};
    vecs[1] = '{"static_c21", 2'd0, 6'd21, {6'd0,  6'd63, 6'd0}};
    vecs[2] = '{"static_c22", 2'd0, 6'd22, {6'd0,  6'd61, 6'd2}};
    vecs[3] = '{"static_c63", 2'd0, 6'd63, {6'd61, 6'd0,  6'd2}};
    vecs[4] = '{"static_c32", 2'd0, 6'd32, {6'd0,  6'd31, 6'd32}};
    vecs[5] = '{"static_c43", 2'd0, 6'd43, {6'd1,  6'd0,  6'd62}};
    vecs[6] = '{"scroll_off0",2'd1, 6'd10, {6'd33, 6'd30, 6'd0}};
    vecs[7] = '{"black_c5",   2'd3, 6'd5,  {6'd0,  6'd0,  6'd0}};
    vecs[8] = '{"solid_off0", 2'd2, 6'd40, {6'd63, 6'd0,  6'd0}};

    // Requests during reset are ignored
    req_valid = 1'b1; column_address = 6'd22;
    tick(); tick(); tick();
    check("reset_hold", 19'd0);
    req_valid = 1'b0;
    reset_n = 1'b1;
    tick();

    // Two-cycle latency, then colour holds with out_valid low
    column_address = 6'd22; mode = 2'd0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("lat_cycle1", 19'd0);
    tick();
    check("lat_cycle2", {1'b1, 6'd0, 6'd61, 6'd2});
    tick();
    check("hold_after", {1'b0, 6'd0, 6'd61, 6'd2});

    foreach (vecs[i]) single(vecs[i].nm, vecs[i].m, vecs[i].c, vecs[i].rgb);

    // 64 back-to-back static requests
    nvalid = 0;
    mode = 2'd0;
    for (int i = 0; i < 67; i++) begin
      if (i < 64) begin
        req_valid = 1'b1; column_address = 6'(i);
      end else begin
        req_valid = 1'b0;
      end
      tick();
      if (out_valid) nvalid++;
      if (i >= 1 && i <= 64) check("b2b_pixel", {1'b1, wheel((i - 1) * 3)});
    end
    total++;
    if (nvalid != 64) begin
      bad++;
      $display("FAIL b2b_count: got %0d valid outputs want 64", nvalid);
    end

    // Scroll forward, speed 10 x 20 frames -> offset 8
    for (int i = 0; i < 20; i++) frame(2'd1, 8'd10, 1'b0);
    single("scroll_off8_solid", 2'd2, 6'd0, {6'd55, 6'd8, 6'd0});
    single("scroll_c63_wrap", 2'd1, 6'd63, {6'd58, 6'd5, 6'd0});

    // Static/black ticks hold the offset
    frame(2'd0, 8'd50, 1'b0);
    frame(2'd3, 8'd50, 1'b0);
    single("hold_in_static", 2'd2, 6'd0, {6'd55, 6'd8, 6'd0});

    // Backwards underflow and speed saturation
    clear_offset();
    frame(2'd1, 8'd1, 1'b1);
    single("dec_underflow", 2'd1, 6'd0, {6'd63, 6'd0, 6'd0});
    single("dec_underflow_solid", 2'd2, 6'd7, {6'd63, 6'd0, 6'd0});
    clear_offset();
    frame(2'd1, 8'd255, 1'b1);
    single("sat_dec", 2'd2, 6'd0, {6'd62, 6'd1, 6'd0});
    clear_offset();
    frame(2'd2, 8'd255, 1'b0);
    frame(2'd2, 8'd0, 1'b0);
    single("sat_inc_zero", 2'd2, 6'd0, {6'd63, 6'd0, 6'd0});

    // Solid at 70; clear beats tick; coincident request sees old offset
    clear_offset();
    frame(2'd2, 8'd70, 1'b0);
    single("solid_70", 2'd2, 6'd9, {6'd0, 6'd57, 6'd6});
    mode = 2'd2; phase_clear = 1'b1; frame_tick = 1'b1; req_valid = 1'b1;
    tick();
    phase_clear = 1'b0; frame_tick = 1'b0; req_valid = 1'b0;
    tick();
    check("coincident_req", {1'b1, 6'd0, 6'd57, 6'd6});
    single("clear_wins", 2'd2, 6'd9, {6'd63, 6'd0, 6'd0});

    // Mode switch on back-to-back requests changes only the second
    column_address = 6'd22; mode = 2'd0; req_valid = 1'b1;
    tick();
    mode = 2'd3;
    tick();
    req_valid = 1'b0;
    check("switch_first", {1'b1, 6'd0, 6'd61, 6'd2});
    tick();
    check("switch_black", {1'b1, 6'd0, 6'd0, 6'd0});

    // Reset mid-stream drops in-flight request and clears offset
    clear_offset();
    frame(2'd2, 8'd70, 1'b0);
    mode = 2'd2; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 check("async_reset", 19'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    check("dropped_inflight", 19'd0);
    single("offset_cleared", 2'd2, 6'd0, {6'd63, 6'd0, 6'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
